// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types, widths and byte-lane helper for the data memory path
package mips_mem_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    function automatic logic [WORD_W-1:0] be_mask(input logic [BE_W-1:0] be);
        for (int i = 0; i < BE_W; i++) be_mask[8*i +: 8] = {8{be[i]}};
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^ADDR_W x 32 RAM, combinational read, synchronous byte-lane write
//   clk            write clock
//   we/be/waddr/wdata  write port; only lanes with be[i]=1 change
//   raddr/rdata    asynchronous read port
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= (mem[waddr] & ~be_mask(be)) | (wdata & be_mask(be));
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data port responder with programmable response latency
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we/addr/be/wdata       request payload (byte address, store lanes, store data)
//   resp_valid/rdata/err       one-cycle response strobe, load data, access error
//   busy                       access outstanding; stalls the pipeline
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY == 0 ? 0 : LATENCY - 1);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept, in_wait, commit, err, mem_we;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [BE_W-1:0]   cur_be;
    logic [WORD_W-1:0] cur_wdata, mem_rdata;

    assign in_wait   = state_q == WAIT;
    assign req_ready = (state_q == IDLE || state_q == RESP) && rst_n;
    assign accept    = req_valid && req_ready;
    assign busy      = rst_n && (in_wait || (accept && LATENCY > 0));

    // The commit source is the latched request after a wait, or the live
    // request when a zero-latency accept commits on its own edge.
    assign cur_we    = in_wait ? we_q    : req_we;
    assign cur_addr  = in_wait ? addr_q  : req_addr;
    assign cur_be    = in_wait ? be_q    : req_be;
    assign cur_wdata = in_wait ? wdata_q : req_wdata;

    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (accept) begin
            state_d = (LATENCY == 0) ? RESP : WAIT;
            cnt_d   = CNT_INIT;
            we_d    = req_we;
            addr_d  = req_addr;
            be_d    = req_be;
            wdata_d = req_wdata;
        end else if (in_wait) begin
            state_d = (cnt_q == 4'd0) ? RESP : WAIT;
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end
    end

    assign commit  = rst_n && state_d == RESP;
    assign err     = cur_addr[1:0] != 2'b00 || (cur_addr >> (ADDR_W + 2)) != 32'd0;
    assign mem_we  = commit && cur_we && !err;
    assign rdata_d = commit ? ((err || cur_we) ? '0 : mem_rdata) : rdata_q;
    assign err_d   = commit ? err : err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk  (clk),
        .we   (mem_we),
        .be   (cur_be),
        .waddr(cur_addr[ADDR_W+1:2]),
        .wdata(cur_wdata),
        .raddr(cur_addr[ADDR_W+1:2]),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for three latency configurations
module tb_dmem_responder;
    localparam int LATS [3] = '{2, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [3:0]  req_be     [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic        busy       [3];

    logic [31:0] mdl [3][16];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.ADDR_W(10), .LATENCY(g == 0 ? 2 : (g == 1 ? 0 : 1))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_be    (req_be[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transaction on instance d, checked against the word model.
    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic e);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] word;
        int n;
        exp_err = addr[1:0] != 2'b00 || addr >= 32'h1000;
        exp_rd  = (exp_err || we) ? 32'd0 : mdl[d][addr[5:2]];
        tests++;
        if (req_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_req d=%0d got %b want 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_be[d]    = be;
        req_wdata[d] = wdata;
        #1;
        tests++;
        if (busy[d] !== (LATS[d] > 0)) begin
            fails++;
            $display("FAIL busy_on_accept d=%0d got %b want %b", d, busy[d], LATS[d] > 0);
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        n = 0;
        while (resp_valid[d] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n != LATS[d]) begin
            fails++;
            $display("FAIL latency d=%0d addr=%h got %0d want %0d", d, addr, n, LATS[d]);
        end
        tests++;
        if (resp_rdata[d] !== exp_rd || resp_err[d] !== exp_err) begin
            fails++;
            $display("FAIL resp d=%0d we=%b addr=%h be=%h got rdata=%h err=%b want rdata=%h err=%b",
                     d, we, addr, be, resp_rdata[d], resp_err[d], exp_rd, exp_err);
        end
        rd = resp_rdata[d];
        e  = resp_err[d];
        if (we && !exp_err) begin
            word = mdl[d][addr[5:2]];
            for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
            mdl[d][addr[5:2]] = word;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (req_ready[d] !== 1'b0 || busy[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_outputs d=%0d got ready=%b busy=%b rv=%b rd=%h err=%b want 0",
                         d, req_ready[d], busy[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic e;
        xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, e);
        xact(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, e);
        tests++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++;
            $display("FAIL full_store_load got %h/%b want deadbeef/0", rd, e);
        end
        xact(0, 1'b1, 32'h10, 4'h1, 32'h000000AA, rd, e);
        xact(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, e);
        tests++;
        if (rd !== 32'hDEADBEAA) begin
            fails++;
            $display("FAIL partial_store got %h want deadbeaa", rd);
        end
        xact(0, 1'b0, 32'h13, 4'h0, 32'h0, rd, e);
        tests++;
        if (rd !== 32'd0 || e !== 1'b1) begin
            fails++;
            $display("FAIL misaligned got %h/%b want 0/1", rd, e);
        end
        xact(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, rd, e);
        tests++;
        if (rd !== 32'd0 || e !== 1'b1) begin
            fails++;
            $display("FAIL out_of_range got %h/%b want 0/1", rd, e);
        end
        xact(0, 1'b1, 32'h11, 4'hF, 32'h55555555, rd, e);
        xact(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, e);
        tests++;
        if (rd !== 32'hDEADBEAA) begin
            fails++;
            $display("FAIL after_errors got %h want deadbeaa", rd);
        end
        xact(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, rd, e);
        xact(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, e);
        tests++;
        if (rd !== 32'hDEADBEAA) begin
            fails++;
            $display("FAIL be_zero got %h want deadbeaa", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        logic e;
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) xact(d, 1'b1, 32'(w * 4), 4'hF, $urandom, rd, e);
            for (int k = 0; k < 60; k++) begin
                case ($urandom_range(0, 5))
                    0: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                    1: addr = ($urandom | 32'h1000) & ~32'h3;
                    default: addr = 32'($urandom_range(0, 15) * 4);
                endcase
                xact(d, 1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom, rd, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_be[1]    = 4'h0;
        for (int i = 0; i < 4; i++) begin
            req_addr[1] = 32'(i * 4);
            #1;
            tests++;
            if (req_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
                fails++;
                $display("FAIL b2b_handshake i=%0d got ready=%b busy=%b want 1/0", i, req_ready[1], busy[1]);
            end
            @(posedge clk);
            #1;
            tests++;
            if (resp_valid[1] !== 1'b1 || resp_rdata[1] !== mdl[1][i] || resp_err[1] !== 1'b0) begin
                fails++;
                $display("FAIL b2b_resp i=%0d got rv=%b rd=%h want 1 %h", i, resp_valid[1], resp_rdata[1], mdl[1][i]);
            end
        end
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (resp_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain got rv=%b busy=%b want 0/0", resp_valid[1], busy[1]);
        end
    endtask

    task automatic test_accept_in_resp();
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 32'h14;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        tests++;
        if (busy[2] !== 1'b1 || resp_valid[2] !== 1'b0) begin
            fails++;
            $display("FAIL air_wait1 got busy=%b rv=%b want 1/0", busy[2], resp_valid[2]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (resp_valid[2] !== 1'b1 || resp_rdata[2] !== mdl[2][5]) begin
            fails++;
            $display("FAIL air_first got rv=%b rd=%h want 1 %h", resp_valid[2], resp_rdata[2], mdl[2][5]);
        end
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h18;
        #1;
        tests++;
        if (req_ready[2] !== 1'b1 || busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL air_accept got ready=%b busy=%b want 1/1", req_ready[2], busy[2]);
        end
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        tests++;
        if (resp_valid[2] !== 1'b0 || busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL air_wait2 got rv=%b busy=%b want 0/1", resp_valid[2], busy[2]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (resp_valid[2] !== 1'b1 || resp_rdata[2] !== mdl[2][6]) begin
            fails++;
            $display("FAIL air_second got rv=%b rd=%h want 1 %h", resp_valid[2], resp_rdata[2], mdl[2][6]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (resp_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
            fails++;
            $display("FAIL air_idle got rv=%b busy=%b want 0/0", resp_valid[2], busy[2]);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic e;
        bit seen;
        xact(0, 1'b1, 32'h20, 4'hF, 32'h11111111, rd, e);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_be[0]    = 4'hF;
        req_wdata[0] = 32'h22222222;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_comb got busy=%b ready=%b want 0/0", busy[0], req_ready[0]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0 || resp_err[0] !== 1'b0 ||
            req_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_outputs got rv=%b rd=%h err=%b ready=%b busy=%b want 0",
                     resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0], busy[0]);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid[0] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL rst_wait_noresp got resp_valid=1 want none");
        end
        xact(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, e);
        tests++;
        if (rd !== 32'h11111111) begin
            fails++;
            $display("FAIL rst_wait_nocommit got %h want 11111111", rd);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'd0;
            req_be[d]    = 4'h0;
            req_wdata[d] = 32'd0;
            for (int w = 0; w < 16; w++) mdl[d][w] = 32'd0;
        end
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_accept_in_resp();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
